// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time controller for a serial pattern detector.
// Holds a programmable pattern (1..MAX_LEN bits, overlapping or non-overlapping detection),
// accepts a valid/ready bit stream into a history shifter, counts matches and raises a
// sticky interrupt when the match count reaches a programmed threshold.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   cfg_we              config write strobe, honoured in IDLE only
//   cfg_pattern/len     pattern (bit [len-1] is received first) and its length
//   cfg_overlap         1 = overlapping detection, 0 = non-overlapping
//   cfg_thresh          match count that moves RUN to DONE; 0 = never
//   cfg_err             1-cycle pulse on an illegal length or a write outside IDLE
//   start/stop/irq_clr  IDLE->RUN, RUN->IDLE, DONE->IDLE
//   bit_valid/bit_in    serial input; bit_ready is high only in RUN
//   det_pulse           1-cycle pulse the cycle after the bit completing a match
//   match_cnt           saturating match count since the last start
//   irq, busy           sticky DONE interrupt; high in RUN or DONE
module seq_det_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_thresh,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         irq_clr,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         bit_ready,
  output logic                         det_pulse,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         irq,
  output logic                         busy
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [MAX_LEN-1:0]   pattern_q;
  logic [LenW-1:0]      len_q;
  logic                 overlap_q;
  logic [CNT_W-1:0]     thresh_q;
  // The oldest history bit is never compared after a shift, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0]   hist_q;
  logic [LenW-1:0]      fill_q;

  logic                 accept;
  logic [MAX_LEN-1:0]   hist_shift;
  logic [MAX_LEN-1:0]   len_mask;
  logic [LenW-1:0]      fill_inc;
  logic                 match;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 thresh_hit;
  logic                 cfg_ok;

  // Match is evaluated on the post-shift history so det_pulse lands one cycle after the bit.
  always_comb begin
    accept     = (state_q == StRun) && bit_valid;
    hist_shift = {hist_q, bit_in};
    fill_inc   = (fill_q == LenW'(MAX_LEN)) ? fill_q : fill_q + LenW'(1);
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match      = accept && (fill_inc >= len_q) &&
                 (((hist_shift ^ pattern_q) & len_mask) == '0);
    cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    thresh_hit = match && (thresh_q != '0) && (cnt_inc == thresh_q);
    cfg_ok     = (cfg_len != '0) && (cfg_len <= LenW'(MAX_LEN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      len_q     <= LenW'(1);
      overlap_q <= 1'b0;
      thresh_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      det_pulse <= 1'b0;
      match_cnt <= '0;
      irq       <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      det_pulse <= 1'b0;
      cfg_err   <= 1'b0;

      if (cfg_we) begin
        if ((state_q == StIdle) && cfg_ok) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          overlap_q <= cfg_overlap;
          thresh_q  <= cfg_thresh;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            hist_q    <= '0;
            fill_q    <= '0;
            match_cnt <= '0;
          end
        end
        StRun: begin
          if (accept) begin
            hist_q <= hist_shift[MAX_LEN-2:0];
            fill_q <= fill_inc;
          end
          if (match) begin
            det_pulse <= 1'b1;
            match_cnt <= cnt_inc;
            // Non-overlapping: the matched bits may not seed the next match.
            if (!overlap_q) begin
              hist_q <= '0;
              fill_q <= '0;
            end
          end
          // An abort takes priority over reaching the threshold on the same edge.
          if (stop) begin
            state_q <= StIdle;
          end else if (thresh_hit) begin
            state_q <= StDone;
            irq     <= 1'b1;
          end
        end
        StDone: begin
          if (irq_clr) begin
            state_q <= StIdle;
            irq     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bit_ready = (state_q == StRun);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_seq_det_ctrl;

  localparam int MaxLen = 8;
  localparam int CntW   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [7:0]      cfg_pattern;
  logic [3:0]      cfg_len;
  logic            cfg_overlap;
  logic [7:0]      cfg_thresh;
  logic            cfg_err;
  logic            start, stop, irq_clr, bit_valid, bit_in;
  logic            bit_ready, det_pulse, irq, busy;
  logic [7:0]      match_cnt;

  seq_det_ctrl #(.MAX_LEN(MaxLen), .CNT_W(CntW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh), .cfg_err(cfg_err), .start(start),
    .stop(stop), .irq_clr(irq_clr), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .det_pulse(det_pulse), .match_cnt(match_cnt), .irq(irq),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int det_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done. History is the list of accepted bits that may
  // still take part in a match.
  int         m_state = 0;
  logic [7:0] m_pat   = 8'd0;
  int         m_len   = 1;
  bit         m_ovl   = 1'b0;
  int         m_thr   = 0;
  bit         hist[$];
  int         m_cnt   = 0;
  bit         m_irq   = 1'b0;
  bit         m_det   = 1'b0;
  bit         m_err   = 1'b0;
  bit         m_hit;

  function automatic bit tail_match();
    if (hist.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (hist[hist.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_pat = 8'd0; m_len = 1; m_ovl = 1'b0; m_thr = 0;
      hist.delete(); m_cnt = 0; m_irq = 1'b0; m_det = 1'b0; m_err = 1'b0;
    end else begin
      m_det = 1'b0;
      m_err = 1'b0;
      m_hit = 1'b0;
      if (cfg_we) begin
        if (m_state == 0 && cfg_len >= 1 && cfg_len <= MaxLen) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          m_thr = int'(cfg_thresh);
        end else begin
          m_err = 1'b1;
        end
      end
      case (m_state)
        0: if (start) begin m_state = 1; hist.delete(); m_cnt = 0; end
        1: begin
          if (bit_valid) begin
            hist.push_back(bit_in);
            if (hist.size() > MaxLen) void'(hist.pop_front());
            if (tail_match()) begin
              m_det = 1'b1;
              if (m_cnt < 255) m_cnt++;
              if (!m_ovl) hist.delete();
              if (m_thr != 0 && m_cnt == m_thr) m_hit = 1'b1;
            end
          end
          if (stop) m_state = 0;
          else if (m_hit) begin m_state = 2; m_irq = 1'b1; end
        end
        default: if (irq_clr) begin m_state = 0; m_irq = 1'b0; end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("bit_ready", bit_ready, m_state == 1);
    chk("busy", busy, m_state != 0);
    chk("irq", irq, m_irq);
    chk("match_cnt", match_cnt, m_cnt);
    chk("det_pulse", det_pulse, m_det);
    chk("cfg_err", cfg_err, m_err);
    if (det_pulse === 1'b1) det_seen++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic [7:0] thr);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_thresh = thr;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1; bit_in = b; step(); bit_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) send(bits[n - 1 - i]);
  endtask

  int d0;

  initial begin
    cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_thresh = 0;
    start = 0; stop = 0; irq_clr = 0; bit_valid = 0; bit_in = 0;
    reset = 1'b1;
    step(); step();
    chk("reset match_cnt", match_cnt, 0);
    chk("reset busy", busy, 0);
    chk("reset bit_ready", bit_ready, 0);
    reset = 1'b0;
    step();

    // 1: non-overlap 1101 on 1101101 -> one match after bit 4
    cfg(8'b1101, 4'd4, 1'b0, 8'd0);
    do_start();
    d0 = det_seen;
    send_seq(16'b1101, 4);
    chk("t1 det after bit4", det_pulse, 1);
    send_seq(16'b101, 3);
    chk("t1 no det after bit7", det_pulse, 0);
    step();
    chk("t1 match_cnt", match_cnt, 1);
    chk("t1 pulses", det_seen - d0, 1);
    do_stop();

    // 2: overlap -> matches after bits 4 and 7
    cfg(8'b1101, 4'd4, 1'b1, 8'd0);
    do_start();
    d0 = det_seen;
    send_seq(16'b1101101, 7);
    chk("t2 det after bit7", det_pulse, 1);
    step();
    chk("t2 match_cnt", match_cnt, 2);
    chk("t2 pulses", det_seen - d0, 2);
    do_stop();

    // 3: threshold 2 -> DONE, bits refused, irq_clr returns to IDLE
    cfg(8'b1101, 4'd4, 1'b1, 8'd2);
    do_start();
    send_seq(16'b1101101, 7);
    chk("t3 irq", irq, 1);
    chk("t3 bit_ready", bit_ready, 0);
    send_seq(16'b1101, 4);
    chk("t3 cnt held", match_cnt, 2);
    chk("t3 busy in done", busy, 1);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    chk("t3 irq cleared", irq, 0);
    chk("t3 busy cleared", busy, 0);

    // 4: illegal lengths and a write during RUN are refused
    cfg(8'hAA, 4'd0, 1'b0, 8'd0);
    chk("t4 err len0", cfg_err, 1);
    cfg(8'hAA, 4'd9, 1'b0, 8'd0);
    chk("t4 err len9", cfg_err, 1);
    do_start();
    cfg(8'hAA, 4'd3, 1'b0, 8'd0);
    chk("t4 err in run", cfg_err, 1);
    send_seq(16'b1101101, 7);
    chk("t4 old cfg irq", irq, 1);
    chk("t4 old cfg cnt", match_cnt, 2);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;

    // 5: gaps with bit_valid low are not shifted
    cfg(8'b1101, 4'd4, 1'b0, 8'd0);
    do_start();
    send(1'b1); bit_in = 1'b0; step();
    send(1'b1); bit_in = 1'b0; step();
    send(1'b0); bit_in = 1'b0; step();
    send(1'b1);
    chk("t5 det", det_pulse, 1);
    step();
    chk("t5 match_cnt", match_cnt, 1);
    do_stop();

    // stop on the edge of a completing bit at threshold: counted, but IDLE and no irq
    cfg(8'b1101, 4'd4, 1'b0, 8'd1);
    do_start();
    send_seq(16'b110, 3);
    bit_valid = 1'b1; bit_in = 1'b1; stop = 1'b1;
    step();
    bit_valid = 1'b0; stop = 1'b0;
    chk("stop det", det_pulse, 1);
    chk("stop cnt", match_cnt, 1);
    chk("stop busy", busy, 0);
    chk("stop irq", irq, 0);

    // 6: reset after 3 bits; config lost, last bit alone does not match
    cfg(8'b1101, 4'd4, 1'b0, 8'd0);
    do_start();
    send_seq(16'b110, 3);
    reset = 1'b1;
    #1;
    chk("t6 rst busy", busy, 0);
    chk("t6 rst bit_ready", bit_ready, 0);
    chk("t6 rst det", det_pulse, 0);
    chk("t6 rst cnt", match_cnt, 0);
    chk("t6 rst irq", irq, 0);
    chk("t6 rst cfg_err", cfg_err, 0);
    step();
    reset = 1'b0;
    step();
    do_start();
    send(1'b1);
    chk("t6 no det", det_pulse, 0);
    step();
    chk("t6 cnt", match_cnt, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
